// File: rtl/operand_entry_fsm_if.sv
// Switch/button inputs and latched-operand outputs of the operand entry stage.
// The master modport drives the raw switches and button; the slave is the entry FSM.
interface operand_entry_fsm_if;
    logic [3:0] dataIn;
    logic       modeIn;
    logic       keyN;
    logic [3:0] opA;
    logic [3:0] opB;
    logic       subMode;
    logic       operandsValid;
    logic [1:0] stateCode;
    logic       pressPulse;

    modport master (
        output dataIn, modeIn, keyN,
        input  opA, opB, subMode, operandsValid, stateCode, pressPulse
    );

    modport slave (
        input  dataIn, modeIn, keyN,
        output opA, opB, subMode, operandsValid, stateCode, pressPulse
    );
endinterface

// File: rtl/operand_entry_fsm.sv
// Button synchroniser, debouncer and press-driven FSM latching operand A, then B and mode.
// Optional WAIT_B idle timeout is built when OPERAND_ENTRY_TIMEOUT_EN is defined.
module operand_entry_fsm #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic                 clock,
    input  logic                 resetn,
    operand_entry_fsm_if.slave   bus
);

    localparam logic [1:0] WAIT_A = 2'b00;
    localparam logic [1:0] WAIT_B = 2'b01;
    localparam logic [1:0] VALID  = 2'b10;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_sync1_q, key_sync2_q;
    logic [1:0]       fill_q, fill_d;
    logic             armed_q, armed_d;
    logic             deb_level_q, deb_level_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press_q, press_d;

    logic [1:0]       state_q, state_d;
    logic [3:0]       op_a_q, op_a_d;
    logic [3:0]       op_b_q, op_b_d;
    logic             sub_q, sub_d;
    logic             valid_q, valid_d;

`ifdef OPERAND_ENTRY_TIMEOUT_EN
    localparam logic [27:0] TO_LAST = 28'(TIMEOUT_CYCLES - 1);
    logic [27:0]      to_cnt_q, to_cnt_d;
    logic             timeout_hit;

    assign timeout_hit = (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q + 28'd1;
        if (state_q != WAIT_B || press_q) begin
            to_cnt_d = '0;
        end
    end
`endif

    // A press only counts once the synchronised key has been seen released
    // after reset; fill_q marks when the synchroniser holds real samples.
    always_comb begin
        fill_d      = {fill_q[0], 1'b1};
        armed_d     = armed_q | (fill_q[1] & key_sync2_q);
        deb_level_d = deb_level_q;
        deb_cnt_d   = deb_cnt_q;
        if (key_sync2_q == deb_level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_level_d = key_sync2_q;
            deb_cnt_d   = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
        press_d = armed_q & deb_level_q & ~deb_level_d;
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sub_d   = sub_q;
        valid_d = valid_q;
        case (state_q)
            WAIT_A: begin
                if (press_q) begin
                    op_a_d  = bus.dataIn;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press_q) begin
                    op_b_d  = bus.dataIn;
                    sub_d   = bus.modeIn;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
`ifdef OPERAND_ENTRY_TIMEOUT_EN
                else if (timeout_hit) begin
                    op_a_d  = 4'd0;
                    state_d = WAIT_A;
                end
`endif
            end
            VALID: begin
                // A press here starts the next calculation directly.
                if (press_q) begin
                    op_a_d  = bus.dataIn;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            key_sync1_q <= 1'b1;
            key_sync2_q <= 1'b1;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            deb_level_q <= 1'b1;
            deb_cnt_q   <= '0;
            press_q     <= 1'b0;
            state_q     <= WAIT_A;
            op_a_q      <= 4'd0;
            op_b_q      <= 4'd0;
            sub_q       <= 1'b0;
            valid_q     <= 1'b0;
`ifdef OPERAND_ENTRY_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            key_sync1_q <= bus.keyN;
            key_sync2_q <= key_sync1_q;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            press_q     <= press_d;
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sub_q       <= sub_d;
            valid_q     <= valid_d;
`ifdef OPERAND_ENTRY_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign bus.opA           = op_a_q;
    assign bus.opB           = op_b_q;
    assign bus.subMode       = sub_q;
    assign bus.operandsValid = valid_q;
    assign bus.stateCode     = state_q;
    assign bus.pressPulse    = press_q;

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Upstream stage of the 4-bit add/subtract datapath with hex display outputs.
- The user enters two operands from one 4-bit switch bank using one pushbutton.
- The block synchronises and debounces the button, then steps a state machine that latches operand A, then operand B and the add/subtract mode.
- It presents stable registered operands and a valid flag to the adder/subtractor and hex decoders.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before the debounced button level changes (10 ms at 50 MHz).
- CNT_W, 20: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- TIMEOUT_CYCLES, 250000000: idle cycles in WAIT_B before abandoning entry. Used only with OPERAND_ENTRY_TIMEOUT_EN.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- dataIn  input  4  raw switch value, sampled on accepted presses.
- modeIn  input  1  raw add/subtract switch: 0 = add, 1 = subtract.
- keyN  input  1  raw pushbutton, active-low, asynchronous and bouncy.
- opA  output  4  latched operand A.
- opB  output  4  latched operand B.
- subMode  output  1  latched mode, captured together with opB.
- operandsValid  output  1  high while opA, opB and subMode form a complete, consistent set.
- stateCode  output  2  current state for LED display: 00 WAIT_A, 01 WAIT_B, 10 VALID.
- pressPulse  output  1  one-cycle strobe for each accepted press; for visibility and verification.

Behaviour:
- Reset: resetn sampled low at a rising edge forces the following values, whatever the current state or debounce progress.
  - state = WAIT_A; opA, opB, subMode, operandsValid, pressPulse = 0.
  - Synchroniser flops = 1; debounced level = 1 (released); debounce counter = 0.
- Synchroniser: keyN passes through two flops before any other use. dataIn and modeIn are not synchronised; they are sampled only on press cycles, so the user holds them static.
- Debounce:
  - If the synchronised level equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
- Press detect: pressPulse is high for exactly one cycle, in the cycle after the debounced level goes 1→0. Release (0→1) generates nothing. Holding the button generates no repeats.
- FSM (state and outputs update at the edge ending the pressPulse cycle):
  - WAIT_A: on pressPulse, opA <= dataIn; go to WAIT_B.
  - WAIT_B: on pressPulse, opB <= dataIn, subMode <= modeIn, operandsValid <= 1; go to VALID.
  - VALID: outputs hold while there is no press. On pressPulse, opA <= dataIn, operandsValid <= 0, opB and subMode hold; go to WAIT_B. This starts the next calculation without a separate clear.
  - Encoding 11 is unreachable; if entered, go to WAIT_A on the next edge with operandsValid <= 0.
- operandsValid is high only in VALID. Downstream treats opA/opB/subMode as meaningful only while it is high.
- Latency: a clean press-edge on keyN gives pressPulse 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later. Outputs change one cycle after pressPulse.
- Reset while WAIT_B or VALID, or mid-debounce: immediate return to reset values. A button still held at reset release produces no press until it has been released and pressed again.

Optional Feature:
- Macro: OPERAND_ENTRY_TIMEOUT_EN.
- Defined:
  - A 28-bit idle counter runs only in WAIT_B. It clears on entry to WAIT_B and on any pressPulse.
  - On reaching TIMEOUT_CYCLES-1 with no press, state goes to WAIT_A and opA <= 0. opB, subMode and operandsValid are unaffected; operandsValid is already 0.
  - A press in the same cycle as the terminal count wins: the normal WAIT_B transition occurs.
- Undefined: no counter is built, and WAIT_B waits indefinitely.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset then idle: resetn low 2 cycles, keyN=1 → stateCode=00, opA=opB=0, operandsValid=0, pressPulse never asserts.
- Full entry:
  - dataIn=5, press keyN low 10 cycles → exactly one pressPulse; opA=5; stateCode=01.
  - Release, then dataIn=3, modeIn=1, press → opB=3, subMode=1, operandsValid=1, stateCode=10.
- Bounce rejection: keyN toggled low/high every 2 cycles for 12 cycles, then held high → no pressPulse, state unchanged. A following clean 8-cycle press → exactly one pulse.
- Restart from VALID: in VALID with opA=5, opB=3, dataIn=9, press → opA=9, opB=3 held, operandsValid=0, stateCode=01.
- Mid-operation reset: in WAIT_B with the button held, assert resetn → all outputs at reset values. Releasing resetn while still holding the button → no pulse until release and re-press.
- Timeout (macro defined): opA=7 latched, no press for 20 cycles → stateCode=00, opA=0. With the macro undefined → state remains 01 after 1000 cycles.
